// File: rtl/hybrid_seq_ctrl_pkg.sv
// hybrid_seq_ctrl_pkg
// Shared definitions for the hybrid AES/RSA sequencer: the sequencer state
// encoding, the default watchdog limit and the AES key/block width.
package hybrid_seq_ctrl_pkg;

  // Default number of cycles a WAIT state may spend without its done
  localparam int TO_MAX_DEF = 4095;

  // AES key and data block width
  localparam int AES_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    RSA_GO,
    RSA_WAIT,
    AES_GO,
    AES_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/hybrid_seq_ctrl_watchdog.sv
// hsc_watchdog
// Timeout counter for the sequencer WAIT states.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - reload the count to zero (asserted in the GO states)
//   en        - count one waiting cycle
//   expired   - high in the waiting cycle that brings the count to TO_MAX
module hsc_watchdog
  import hybrid_seq_ctrl_pkg::*;
#(
  parameter int TO_MAX = TO_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TO_MAX + 1);

  logic [CW-1:0] count;

  // Count waiting cycles; clr reloads zero at the start of every core launch
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // The current cycle is the TO_MAX-th one without done, so the FSM can
  // leave the WAIT state on the same edge the count would reach TO_MAX
  assign expired = en && (count == CW'(TO_MAX - 1));

endmodule

// File: rtl/hybrid_seq_ctrl.sv
// hybrid_seq_ctrl
// Sequences one hybrid crypto request: RSA wrap (encrypt) or unwrap
// (decrypt) of the session key, then an AES operation with the proper key,
// then a response carrying the AES result and, on encrypt, the wrapped key.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake
//   req_enc, req_key, req_data    - request operation, key and AES block
//   rsa_start, rsa_enc_dec, rsa_d_in, rsa_done, rsa_d_o - RSA core port
//   aes_start, aes_enc_dec, aes_key, aes_d_in, aes_done, aes_d_o - AES port
//   rsp_valid/rsp_ready           - response handshake
//   rsp_data, rsp_wkey, rsp_err   - AES result, wrapped key, timeout flag
//   busy                          - a transaction is in flight
module hybrid_seq_ctrl
  import hybrid_seq_ctrl_pkg::*;
#(
  parameter int W      = 1024,
  parameter int TO_MAX = TO_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_enc,
  input  logic [W-1:0]     req_key,
  input  logic [AES_W-1:0] req_data,
  output logic             rsa_start,
  output logic             rsa_enc_dec,
  output logic [W-1:0]     rsa_d_in,
  input  logic             rsa_done,
  input  logic [2*W-1:0]   rsa_d_o,
  output logic             aes_start,
  output logic             aes_enc_dec,
  output logic [AES_W-1:0] aes_key,
  output logic [AES_W-1:0] aes_d_in,
  input  logic             aes_done,
  input  logic [AES_W-1:0] aes_d_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [AES_W-1:0] rsp_data,
  output logic [2*W-1:0]   rsp_wkey,
  output logic             rsp_err,
  output logic             busy
);

  state_t           state;
  logic             done_seen;
  logic [AES_W-1:0] data_q;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expired;

  // The watchdog restarts in each GO state and counts WAIT cycles that have
  // neither a captured done nor a done arriving right now
  always_comb begin
    wd_clr = (state == RSA_GO) || (state == AES_GO);
    wd_en  = 1'b0;
    if (!done_seen) begin
      if ((state == RSA_WAIT) && !rsa_done) wd_en = 1'b1;
      if ((state == AES_WAIT) && !aes_done) wd_en = 1'b1;
    end
  end

  hsc_watchdog #(
    .TO_MAX (TO_MAX)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Main sequencer. rsa_d_in and rsa_enc_dec double as the latched request
  // key and operation. A done is only looked at in its WAIT state, so a
  // level left over from a previous job or present during GO has no effect.
  // The done is first captured (together with the core result) and acted on
  // one cycle later, which keeps the core result paths registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_seen   <= 1'b0;
      data_q      <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsa_start   <= 1'b0;
      rsa_enc_dec <= 1'b0;
      rsa_d_in    <= '0;
      aes_start   <= 1'b0;
      aes_enc_dec <= 1'b0;
      aes_key     <= '0;
      aes_d_in    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_wkey    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsa_start <= 1'b0;
      aes_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rsa_enc_dec <= req_enc;
            rsa_d_in    <= req_key;
            data_q      <= req_data;
            rsa_start   <= 1'b1;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= RSA_GO;
          end
        end
        RSA_GO: begin
          done_seen <= 1'b0;
          state     <= RSA_WAIT;
        end
        RSA_WAIT: begin
          if (done_seen) begin
            done_seen   <= 1'b0;
            aes_enc_dec <= rsa_enc_dec;
            aes_d_in    <= data_q;
            aes_start   <= 1'b1;
            state       <= AES_GO;
          end else if (rsa_done) begin
            // Encrypt keeps the plaintext key for AES and returns the wrapped
            // key; decrypt uses the unwrapped key and returns nothing
            done_seen <= 1'b1;
            rsp_wkey  <= rsa_enc_dec ? rsa_d_o : '0;
            aes_key   <= rsa_enc_dec ? rsa_d_in[AES_W-1:0] : rsa_d_o[AES_W-1:0];
          end else if (wd_expired) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_wkey  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        AES_GO: begin
          state <= AES_WAIT;
        end
        AES_WAIT: begin
          if (done_seen) begin
            done_seen <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (aes_done) begin
            done_seen <= 1'b1;
            rsp_data  <= aes_d_o;
          end else if (wd_expired) begin
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_wkey  <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            rsp_wkey  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hybrid_seq_ctrl.sv
// tb_hybrid_seq_ctrl
// Directed bench for hybrid_seq_ctrl. A main instance runs the functional
// sequences against simple RSA/AES core models; a second instance with a
// short watchdog limit and silent cores covers the timeout path.
module tb_hybrid_seq_ctrl;

  localparam int W  = 256;
  localparam int W2 = 2 * W;

  localparam logic [127:0] EKEY  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] EDATA = 128'h328831e0435a3137f6309807a88da234;
  localparam logic [127:0] DKEY  = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] DDATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RDATA = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [W2-1:0] RSA_ENC = {8{64'h0f1e2d3c4b5a6978}};
  localparam logic [W2-1:0] RSA_DEC = {{(W2-128){1'b1}}, DKEY};
  localparam logic [W-1:0]  EKEY_W  = {{(W-128){1'b1}}, EKEY};
  localparam logic [W-1:0]  DKEY_W  = {2{128'hc0ffee00c0ffee11c0ffee22c0ffee33}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_enc;
  logic [W-1:0]    req_key;
  logic [127:0]    req_data;
  logic            rsa_start;
  logic            rsa_enc_dec;
  logic [W-1:0]    rsa_d_in;
  logic            rsa_done;
  logic [W2-1:0]   rsa_d_o;
  logic            aes_start;
  logic            aes_enc_dec;
  logic [127:0]    aes_key;
  logic [127:0]    aes_d_in;
  logic            aes_done;
  logic [127:0]    aes_d_o;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [127:0]    rsp_data;
  logic [W2-1:0]   rsp_wkey;
  logic            rsp_err;
  logic            busy;

  logic            req_valid_t;
  logic            req_ready_t;
  logic            rsa_start_t;
  logic            rsa_enc_dec_t;
  logic [W-1:0]    rsa_d_in_t;
  logic            aes_start_t;
  logic            aes_enc_dec_t;
  logic [127:0]    aes_key_t;
  logic [127:0]    aes_d_in_t;
  logic            rsp_valid_t;
  logic            rsp_ready_t;
  logic [127:0]    rsp_data_t;
  logic [W2-1:0]   rsp_wkey_t;
  logic            rsp_err_t;
  logic            busy_t;

  int errors = 0;
  int checks = 0;

  int rsa_lat = 1;
  int aes_lat = 1;
  int rsa_cnt = 0;
  int aes_cnt = 0;
  int rsa_starts = 0;
  int aes_starts = 0;
  int t_rsa_starts = 0;
  int t_aes_starts = 0;
  logic rsa_done_m = 1'b0;
  logic rsa_stale = 1'b0;
  logic [W2-1:0] rsa_res = '0;

  assign rsa_done = rsa_done_m | rsa_stale;
  assign rsa_d_o  = rsa_res;

  hybrid_seq_ctrl #(.W(W), .TO_MAX(4095)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc),
    .req_key(req_key), .req_data(req_data),
    .rsa_start(rsa_start), .rsa_enc_dec(rsa_enc_dec), .rsa_d_in(rsa_d_in),
    .rsa_done(rsa_done), .rsa_d_o(rsa_d_o),
    .aes_start(aes_start), .aes_enc_dec(aes_enc_dec), .aes_key(aes_key),
    .aes_d_in(aes_d_in), .aes_done(aes_done), .aes_d_o(aes_d_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wkey(rsp_wkey), .rsp_err(rsp_err), .busy(busy)
  );

  hybrid_seq_ctrl #(.W(W), .TO_MAX(15)) dut_to (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_t), .req_ready(req_ready_t), .req_enc(req_enc),
    .req_key(req_key), .req_data(req_data),
    .rsa_start(rsa_start_t), .rsa_enc_dec(rsa_enc_dec_t), .rsa_d_in(rsa_d_in_t),
    .rsa_done(1'b0), .rsa_d_o({W2{1'b0}}),
    .aes_start(aes_start_t), .aes_enc_dec(aes_enc_dec_t), .aes_key(aes_key_t),
    .aes_d_in(aes_d_in_t), .aes_done(1'b0), .aes_d_o(128'h0),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_data(rsp_data_t),
    .rsp_wkey(rsp_wkey_t), .rsp_err(rsp_err_t), .busy(busy_t)
  );

  // RSA core model: done pulses rsa_lat cycles after the start cycle
  always @(negedge clk) begin
    rsa_done_m = 1'b0;
    if (rsa_cnt > 0) begin
      rsa_cnt = rsa_cnt - 1;
      if (rsa_cnt == 0) rsa_done_m = 1'b1;
    end
    if (rsa_start) begin
      rsa_starts = rsa_starts + 1;
      rsa_cnt = rsa_lat;
    end
  end

  // AES core model: returns data^key aes_lat cycles after the start cycle
  always @(negedge clk) begin
    aes_done = 1'b0;
    if (aes_cnt > 0) begin
      aes_cnt = aes_cnt - 1;
      if (aes_cnt == 0) begin
        aes_done = 1'b1;
        aes_d_o  = aes_d_in ^ aes_key;
      end
    end
    if (aes_start) begin
      aes_starts = aes_starts + 1;
      aes_cnt = aes_lat;
    end
  end

  // Start pulse counters for the timeout instance
  always @(negedge clk) begin
    if (rsa_start_t) t_rsa_starts = t_rsa_starts + 1;
    if (aes_start_t) t_aes_starts = t_aes_starts + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [W2-1:0] obs,
                             input logic [W2-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic enc, input logic [W-1:0] key,
                               input logic [127:0] data);
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin
      tick();
      guard++;
    end
    req_enc   = enc;
    req_key   = key;
    req_data  = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitResp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stopped");
  end

  initial begin
    int n;
    int g;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_enc     = 1'b0;
    req_key     = '0;
    req_data    = '0;
    rsp_ready   = 1'b0;
    req_valid_t = 1'b0;
    rsp_ready_t = 1'b0;
    repeat (3) tick();

    // Reset values
    checkOutput("rst_req_ready", W2'(req_ready), W2'(1));
    checkOutput("rst_busy", W2'(busy), W2'(0));
    checkOutput("rst_rsp_valid", W2'(rsp_valid), W2'(0));
    checkOutput("rst_rsp_err", W2'(rsp_err), W2'(0));
    checkOutput("rst_rsa_start", W2'(rsa_start), W2'(0));
    checkOutput("rst_aes_start", W2'(aes_start), W2'(0));
    checkOutput("rst_rsp_data", W2'(rsp_data), W2'(0));
    checkOutput("rst_rsp_wkey", rsp_wkey, W2'(0));
    checkOutput("rst_aes_key", W2'(aes_key), W2'(0));
    checkOutput("rst_rsa_d_in", W2'(rsa_d_in), W2'(0));
    checkOutput("rst_to_req_ready", W2'(req_ready_t), W2'(1));
    rst = 1'b0;
    tick();

    // Encrypt: RSA 20 cycles, AES 11 cycles
    $display("[TB] encrypt");
    rsa_res = RSA_ENC; rsa_lat = 20; aes_lat = 11;
    rsa_starts = 0; aes_starts = 0;
    applyStimulus(1'b1, EKEY_W, EDATA);
    checkOutput("enc_busy", W2'(busy), W2'(1));
    checkOutput("enc_req_ready", W2'(req_ready), W2'(0));
    checkOutput("enc_rsa_start", W2'(rsa_start), W2'(1));
    checkOutput("enc_rsa_d_in", W2'(rsa_d_in), W2'(EKEY_W));
    checkOutput("enc_rsa_enc_dec", W2'(rsa_enc_dec), W2'(1));
    waitResp(n);
    checkOutput("enc_latency", W2'(n), W2'(35));
    checkOutput("enc_rsa_starts", W2'(rsa_starts), W2'(1));
    checkOutput("enc_aes_starts", W2'(aes_starts), W2'(1));
    checkOutput("enc_aes_key", W2'(aes_key), W2'(EKEY));
    checkOutput("enc_rsp_wkey", rsp_wkey, RSA_ENC);
    checkOutput("enc_rsp_data", W2'(rsp_data), W2'(EKEY ^ EDATA));
    checkOutput("enc_rsp_err", W2'(rsp_err), W2'(0));
    rsp_ready = 1'b1;
    tick();
    checkOutput("enc_done_valid", W2'(rsp_valid), W2'(0));
    checkOutput("enc_done_ready", W2'(req_ready), W2'(1));
    checkOutput("enc_done_busy", W2'(busy), W2'(0));

    // Decrypt with 10 cycles of response backpressure
    $display("[TB] decrypt with backpressure");
    rsp_ready = 1'b0;
    rsa_res = RSA_DEC; rsa_lat = 3; aes_lat = 2;
    rsa_starts = 0; aes_starts = 0;
    applyStimulus(1'b0, DKEY_W, DDATA);
    waitResp(n);
    checkOutput("dec_latency", W2'(n), W2'(9));
    checkOutput("dec_aes_key", W2'(aes_key), W2'(DKEY));
    checkOutput("dec_aes_enc_dec", W2'(aes_enc_dec), W2'(0));
    checkOutput("dec_rsp_wkey", rsp_wkey, W2'(0));
    checkOutput("dec_rsp_data", W2'(rsp_data), W2'(DDATA ^ DKEY));
    checkOutput("dec_rsa_d_in", W2'(rsa_d_in), W2'(DKEY_W));
    for (int i = 0; i < 10; i++) begin
      req_valid = ~req_valid;
      tick();
      checkOutput("bp_rsp_valid", W2'(rsp_valid), W2'(1));
      checkOutput("bp_req_ready", W2'(req_ready), W2'(0));
      checkOutput("bp_rsp_data", W2'(rsp_data), W2'(DDATA ^ DKEY));
    end
    req_valid = 1'b0;
    checkOutput("bp_rsa_starts", W2'(rsa_starts), W2'(1));
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_done_valid", W2'(rsp_valid), W2'(0));
    checkOutput("bp_done_ready", W2'(req_ready), W2'(1));

    // rsp_ready held high in advance, then a back-to-back request whose
    // RSA done level is still high from before and during RSA_GO
    $display("[TB] back-to-back and stale done");
    rsa_res = RSA_ENC; rsa_lat = 1; aes_lat = 1;
    applyStimulus(1'b1, EKEY_W, EDATA);
    waitResp(n);
    checkOutput("b2b_latency", W2'(n), W2'(6));
    tick();
    checkOutput("b2b_one_cycle_valid", W2'(rsp_valid), W2'(0));
    checkOutput("b2b_idle_ready", W2'(req_ready), W2'(1));
    rsa_stale = 1'b1;
    rsa_lat = 5; aes_lat = 2;
    rsa_starts = 0;
    applyStimulus(1'b1, EKEY_W, RDATA);
    checkOutput("b2b_accepted", W2'(busy), W2'(1));
    tick();
    rsa_stale = 1'b0;
    waitResp(n);
    checkOutput("stale_latency", W2'(n + 1), W2'(11));
    checkOutput("stale_rsp_data", W2'(rsp_data), W2'(EKEY ^ RDATA));
    checkOutput("stale_rsp_wkey", rsp_wkey, RSA_ENC);
    checkOutput("stale_rsa_starts", W2'(rsa_starts), W2'(1));
    tick();

    // Timeout instance: RSA done never arrives, TO_MAX = 15
    $display("[TB] timeout");
    t_rsa_starts = 0; t_aes_starts = 0;
    req_enc = 1'b1; req_key = EKEY_W; req_data = EDATA;
    req_valid_t = 1'b1;
    tick();
    req_valid_t = 1'b0;
    checkOutput("to_busy", W2'(busy_t), W2'(1));
    n = 0;
    while (!rsp_valid_t && n < 100) begin
      tick();
      n++;
    end
    checkOutput("to_latency", W2'(n), W2'(16));
    checkOutput("to_rsp_err", W2'(rsp_err_t), W2'(1));
    checkOutput("to_rsp_data", W2'(rsp_data_t), W2'(0));
    checkOutput("to_rsp_wkey", rsp_wkey_t, W2'(0));
    checkOutput("to_rsa_starts", W2'(t_rsa_starts), W2'(1));
    checkOutput("to_aes_starts", W2'(t_aes_starts), W2'(0));
    rsp_ready_t = 1'b1;
    tick();
    checkOutput("to_err_clear", W2'(rsp_err_t), W2'(0));
    checkOutput("to_valid_clear", W2'(rsp_valid_t), W2'(0));
    checkOutput("to_req_ready", W2'(req_ready_t), W2'(1));

    // Reset asserted in AES_WAIT
    $display("[TB] reset during AES_WAIT");
    rsp_ready = 1'b0;
    rsa_lat = 2; aes_lat = 6;
    rsa_starts = 0; aes_starts = 0;
    applyStimulus(1'b1, EKEY_W, EDATA);
    g = 0;
    while (!aes_start && g < 50) begin
      tick();
      g++;
    end
    checkOutput("rstop_aes_go_seen", W2'(aes_start), W2'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstop_busy", W2'(busy), W2'(0));
    checkOutput("rstop_rsp_valid", W2'(rsp_valid), W2'(0));
    checkOutput("rstop_req_ready", W2'(req_ready), W2'(1));
    repeat (10) tick();
    checkOutput("rstop_still_idle", W2'(rsp_valid), W2'(0));
    checkOutput("rstop_rsa_starts", W2'(rsa_starts), W2'(1));
    checkOutput("rstop_aes_starts", W2'(aes_starts), W2'(1));
    rsa_lat = 1; aes_lat = 1;
    applyStimulus(1'b1, EKEY_W, RDATA);
    waitResp(n);
    checkOutput("rstop_next_latency", W2'(n), W2'(6));
    checkOutput("rstop_next_data", W2'(rsp_data), W2'(EKEY ^ RDATA));
    checkOutput("rstop_next_wkey", rsp_wkey, RSA_ENC);
    rsp_ready = 1'b1;
    tick();
    checkOutput("rstop_next_done", W2'(rsp_valid), W2'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hybrid_seq_ctrl.md
# hybrid_seq_ctrl

Sequencer for the hybrid AES/RSA crypto path. Accepts one request at a time over a valid/ready handshake and drives the RSA core first: it wraps the session key on encrypt and unwraps it on decrypt. It then drives the AES core with the correct 128-bit key and returns the AES result, plus the wrapped key on encrypt, over a second valid/ready handshake. It sits between the host request interface and the AES/RSA cores and replaces free-running key muxing with explicit start/done sequencing and a watchdog.

## Interface
- `W`, 1024, RSA operand width.
- `TO_MAX`, 4095, maximum cycles spent waiting for any core done before a timeout.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_enc` in 1: 1 = encrypt, 0 = decrypt.
- `req_key` in W: encrypt = plaintext session key in [127:0]; decrypt = RSA-wrapped key.
- `req_data` in 128: AES input block.
- `rsa_start` out 1: one-cycle start pulse to the RSA core.
- `rsa_enc_dec` out 1, `rsa_d_in` out W: RSA operands, held stable from `rsa_start` until `rsa_done`.
- `rsa_done` in 1, `rsa_d_o` in 2W: RSA completion and result.
- `aes_start` out 1: one-cycle pulse.
- `aes_enc_dec` out 1, `aes_key` out 128, `aes_d_in` out 128: AES operands, held stable while in AES states.
- `aes_done` in 1, `aes_d_o` in 128: AES completion and result.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out 128: AES result.
- `rsp_wkey` out 2W: wrapped key on encrypt, all-zero on decrypt.
- `rsp_err` out 1: timeout occurred.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, RSA_GO, RSA_WAIT, AES_GO, AES_WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, register `req_enc`, `req_key`, `req_data`; go to RSA_GO.
- RSA_GO:
  - `rsa_start`=1 for exactly this cycle.
  - `rsa_enc_dec`=latched enc; `rsa_d_in`=latched key.
  - Clear the timeout counter; go to RSA_WAIT.
- RSA_WAIT:
  - On the first cycle with `rsa_done`=1, capture `rsa_d_o`.
  - AES key = latched key[127:0] on encrypt, or `rsa_d_o`[127:0] on decrypt.
  - Go to AES_GO.
- AES_GO:
  - `aes_start` pulse; `aes_enc_dec`=latched enc; `aes_d_in`=latched data.
  - Clear the counter; go to AES_WAIT.
- AES_WAIT:
  - On `aes_done`, capture `aes_d_o` into `rsp_data`; go to RESP.
- RESP:
  - `rsp_valid`=1, outputs held until `rsp_valid&&rsp_ready`, then go to IDLE.
  - `rsp_wkey` = captured `rsa_d_o` on encrypt, 0 on decrypt.
- Done inputs are sampled only in their WAIT state. A `done` that is high during a GO state, or a stale `done` still high from the previous operation, is ignored; WAIT acts on `done` sampled from the cycle after the GO state.
- Timeout:
  - The counter increments every WAIT cycle without the matching `done`.
  - When it reaches `TO_MAX`: go to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_wkey`=0, and no AES launch.
  - `rsp_err` clears when the response is accepted.
- No new request is accepted until the response handshake completes: `req_ready`=0 outside IDLE.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_err`=0. All start pulses, operand outputs, `rsp_data` and `rsp_wkey` are 0. State is IDLE. The counter is 0.
- `rst` mid-operation returns to IDLE next cycle, abandons the transaction, and issues no further start pulses.
- Latency from request accept to `rsp_valid` = 2 + Trsa + 2 + Taes cycles.
  - Trsa and Taes are the cycles from start pulse to the first sampled `done`; each is ≥1.
- The start pulse is registered, so it is high in the cycle after entry to the GO state is decided, and never for two consecutive cycles.
- Back-to-back: IDLE is reachable in the cycle after the response is accepted, so the next request can be accepted one cycle after the response handshake.
- `rsp_ready` may be held high in advance; the response then completes in its first RESP cycle.

## Structure
- A shared package holds the state enum, the `TO_MAX` default, and the AES key width constant 128.
- One sub-module is natural: `hsc_watchdog`, a loadable timeout counter with `clr`, `en` and `expired` signals.
- Operand and result registers and the FSM stay in the top module.

## Test plan
- Encrypt:
  - Stimulus: `req_key`=128'h2b28ab097eaef7cf15d2154f16a6883c, `req_data`=128'h328831e0435a3137f6309807a88da234. The RSA model returns a fixed 2W value after 20 cycles; the AES model echoes `data^key` after 11 cycles.
  - Required: one `rsa_start` and one `aes_start` pulse, `aes_key`=2b28…883c, `rsp_wkey`=RSA model value, `rsp_data`=`data^key`. `rsp_valid` rises 35 cycles after accept.
- Decrypt:
  - Stimulus: the RSA model returns `rsa_d_o`[127:0]=128'h0123456789abcdef0011223344556677.
  - Required: `aes_key` equals that value, `rsp_wkey`=0.
- Timeout:
  - Stimulus: with `TO_MAX`=15, `rsa_done` is never asserted.
  - Required: `rsp_valid` with `rsp_err`=1 after 15 RSA_WAIT cycles, `aes_start` never pulses, `rsp_data`=0.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 10 cycles and toggle `req_valid` meanwhile.
  - Required: outputs stable, `req_ready`=0, no second transaction starts.
- Stale done:
  - Stimulus: `rsa_done` is held high from the previous operation.
  - Required: RSA_WAIT acts on `done` from the cycle after RSA_GO; the stale level is ignored.
- Reset:
  - Stimulus: assert `rst` in AES_WAIT.
  - Required: next cycle IDLE, `busy`=0, `rsp_valid`=0; a following request completes normally.
